tx_packet_arbiter: RTL

- Packet-atomic arbiter that shares the single TSE transmit Avalon-ST port between two packet sources: channel 0 is the UDP path (after alignment) and channel 1 is the ARP reply path.
- Grants whole packets from SOP to EOP, with fixed priority plus a bounded-burst fairness rule.
- Sits between the UDP/ARP generators and the TSE MAC transmit interface.
- Provides per-channel packet counters and an orphan-beat error counter.

---
 rtl/tx_packet_arbiter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/tx_packet_arbiter.sv
// Packet-atomic two-channel arbiter for the shared TSE transmit Avalon-ST port (ch0 = UDP, ch1 = ARP).
// Latency: 1-cycle arbitration in IDLE, then zero-latency combinational pass-through of the granted packet.
// Backpressure: avso_ready goes straight back to the granted channel; the other channel is held off until EOP.
module tx_packet_arbiter #(
   parameter int DATA_W    = 32,
   parameter int EMPTY_W   = 2,
   parameter int PRIO_CH   = 1,
   parameter int MAX_BURST = 4,
   parameter int CNT_W     = 16
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [DATA_W-1:0]  avsi_ch0_data,
   input  logic               avsi_ch0_valid,
   input  logic               avsi_ch0_sop,
   input  logic               avsi_ch0_eop,
   input  logic [EMPTY_W-1:0] avsi_ch0_empty,
   output logic               avsi_ch0_ready,
   input  logic [DATA_W-1:0]  avsi_ch1_data,
   input  logic               avsi_ch1_valid,
   input  logic               avsi_ch1_sop,
   input  logic               avsi_ch1_eop,
   input  logic [EMPTY_W-1:0] avsi_ch1_empty,
   output logic               avsi_ch1_ready,
   output logic [DATA_W-1:0]  avso_data,
   output logic               avso_valid,
   output logic               avso_sop,
   output logic               avso_eop,
   output logic [EMPTY_W-1:0] avso_empty,
   input  logic               avso_ready,
   output logic               avso_channel,
   output logic [CNT_W-1:0]   stat_pkt_cnt0,
   output logic [CNT_W-1:0]   stat_pkt_cnt1,
   output logic [CNT_W-1:0]   stat_orphan_cnt
);

   // Burst counter must hold 0..MAX_BURST; keep at least one bit for strict priority.
   localparam int                 BURST_W   = (MAX_BURST < 1) ? 1 : $clog2(MAX_BURST + 1);
   localparam logic               PRIO_BIT  = (PRIO_CH != 0);
   localparam logic               FAIR_EN   = (MAX_BURST > 0);
   localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT0 = 2'd1,
      GRANT1 = 2'd2
   } state_t;

   state_t             state;
   logic               chan_q;
   logic [BURST_W-1:0] burst_cnt;
   logic [CNT_W-1:0]   pkt_cnt0;
   logic [CNT_W-1:0]   pkt_cnt1;
   logic [CNT_W-1:0]   orphan_cnt;

   logic req0, req1, orph0, orph1;
   logic other_req, fair_turn, grant_ch;
   logic pkt_end0, pkt_end1;

   assign req0      = avsi_ch0_valid & avsi_ch0_sop;
   assign req1      = avsi_ch1_valid & avsi_ch1_sop;
   assign orph0     = avsi_ch0_valid & ~avsi_ch0_sop;
   assign orph1     = avsi_ch1_valid & ~avsi_ch1_sop;
   assign other_req = PRIO_BIT ? req0 : req1;
   assign fair_turn = FAIR_EN && (burst_cnt == BURST_MAX);
   assign pkt_end0  = (state == GRANT0) & avsi_ch0_valid & avso_ready & avsi_ch0_eop;
   assign pkt_end1  = (state == GRANT1) & avsi_ch1_valid & avso_ready & avsi_ch1_eop;

   // Pick the winner when arbitrating: priority channel unless its burst allowance is used up.
   always_comb begin
      grant_ch = req1;
      if (req0 && req1) begin
         grant_ch = fair_turn ? ~PRIO_BIT : PRIO_BIT;
      end
   end

   // Output mux: orphan drop in IDLE, straight pass-through of the granted channel otherwise.
   // Gated by reset_n so outputs sit at their reset values while reset is held.
   always_comb begin
      avso_data      = '0;
      avso_valid     = 1'b0;
      avso_sop       = 1'b0;
      avso_eop       = 1'b0;
      avso_empty     = '0;
      avsi_ch0_ready = 1'b0;
      avsi_ch1_ready = 1'b0;
      if (reset_n) begin
         case (state)
            IDLE: begin
               avsi_ch0_ready = orph0;
               avsi_ch1_ready = orph1;
            end
            GRANT0: begin
               avso_data      = avsi_ch0_data;
               avso_valid     = avsi_ch0_valid;
               avso_sop       = avsi_ch0_sop;
               avso_eop       = avsi_ch0_eop;
               avso_empty     = avsi_ch0_empty;
               avsi_ch0_ready = avso_ready;
            end
            GRANT1: begin
               avso_data      = avsi_ch1_data;
               avso_valid     = avsi_ch1_valid;
               avso_sop       = avsi_ch1_sop;
               avso_eop       = avsi_ch1_eop;
               avso_empty     = avsi_ch1_empty;
               avsi_ch1_ready = avso_ready;
            end
            default: ;
         endcase
      end
   end

   // Grant FSM: arbitrate in IDLE, hold the grant until the EOP handshake, track the priority burst.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         chan_q    <= 1'b0;
         burst_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req0 || req1) begin
                  state  <= grant_ch ? GRANT1 : GRANT0;
                  chan_q <= grant_ch;
                  if ((grant_ch == PRIO_BIT) && other_req) begin
                     burst_cnt <= (burst_cnt == BURST_MAX) ? burst_cnt : burst_cnt + 1'b1;
                  end else begin
                     burst_cnt <= '0;
                  end
               end
            end
            GRANT0: if (pkt_end0) state <= IDLE;
            GRANT1: if (pkt_end1) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Statistics: packets completed per channel and orphan beats discarded in IDLE; all wrap.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pkt_cnt0   <= '0;
         pkt_cnt1   <= '0;
         orphan_cnt <= '0;
      end else begin
         if (pkt_end0) pkt_cnt0 <= pkt_cnt0 + 1'b1;
         if (pkt_end1) pkt_cnt1 <= pkt_cnt1 + 1'b1;
         if (state == IDLE) orphan_cnt <= orphan_cnt + CNT_W'(orph0) + CNT_W'(orph1);
      end
   end

   assign avso_channel    = chan_q;
   assign stat_pkt_cnt0   = pkt_cnt0;
   assign stat_pkt_cnt1   = pkt_cnt1;
   assign stat_orphan_cnt = orphan_cnt;

endmodule
